stack_mem_responder: RTL and testbench



---
 rtl/stack_mem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_stack_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_responder.sv
// stack_mem_responder
//   Memory-side responder for the stack CPU. One request/acknowledge
//   transaction at a time: optional write, then a two-word read
//   (OP1 = mem[RADDR], OP2 = mem[RADDR+1]), with programmable wait states
//   between accept and the memory accesses.
//
//   Backing store is an internal single-port RAM: the write (WR) and the two
//   reads (RD1, RD2) happen in separate cycles through one shared address.
//
// Optional feature macro: MEMRESP_STATS_EN
//   When defined, adds o_XFER_CNT, a saturating count of completed
//   transactions (including ones flagged with o_ERR).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   i_REQ      request strobe, sampled only in IDLE
//   i_WE       write enable for the transaction
//   i_RADDR    read base address (16 bit)
//   i_WADDR    write address (16 bit)
//   i_WDATA    write data
//   o_ACK      one-cycle completion pulse
//   o_OP1      mem[RADDR]   (0 when out of range)
//   o_OP2      mem[RADDR+1] (0 when out of range, address wraps at 16 bits)
//   o_BUSY     high in every state except IDLE
//   o_ERR      out-of-range flag, valid with o_ACK
//   o_XFER_CNT transaction counter (MEMRESP_STATS_EN only)

module stack_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_REQ,
  input  logic              i_WE,
  input  logic [15:0]       i_RADDR,
  input  logic [15:0]       i_WADDR,
  input  logic [DATA_W-1:0] i_WDATA,
  output logic              o_ACK,
  output logic [DATA_W-1:0] o_OP1,
  output logic [DATA_W-1:0] o_OP2,
  output logic              o_BUSY,
  output logic              o_ERR
`ifdef MEMRESP_STATS_EN
  ,
  output logic [15:0]       o_XFER_CNT
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_WR   = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4,
    ST_ACK  = 3'd5
  } state_t;

  // With no wait states the accept goes straight to the write slot.
  localparam state_t     ST_AFTER_ACCEPT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_WR;
  // Last value of the wait counter; only reachable when WAIT_CYCLES > 0.
  localparam logic [3:0] WAIT_LAST       = 4'(WAIT_CYCLES - 1);

  // An address is usable when it lies below the RAM size.
  function automatic logic addr_in_range(input logic [15:0] addr);
    return ({16'd0, addr} < (32'd1 << DEPTH_LOG2));
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic [3:0]              wait_cnt_r;
  logic [3:0]              wait_cnt_next_s;

  logic                    we_r;
  logic [15:0]             raddr_r;
  logic [15:0]             waddr_r;
  logic [DATA_W-1:0]       wdata_r;

  logic [15:0]             raddr_p1_s;
  logic                    err_s;

  logic [15:0]             mem_addr_s;
  logic [DEPTH_LOG2-1:0]   mem_idx_s;
  logic                    mem_ok_s;
  logic [DATA_W-1:0]       ram_q_s;
  logic [DATA_W-1:0]       ram_r [(2**DEPTH_LOG2)];

  logic                    ack_r;
  logic                    busy_r;
  logic                    err_r;
  logic [DATA_W-1:0]       op1_r;
  logic [DATA_W-1:0]       op2_r;

  // Second read address wraps at 16 bits before the range check.
  assign raddr_p1_s = raddr_r + 16'd1;

  // Any address actually used by the transaction being out of range.
  assign err_s = (we_r & ~addr_in_range(waddr_r))
               | ~addr_in_range(raddr_r)
               | ~addr_in_range(raddr_p1_s);

  // Single shared RAM address, selected by the access slot.
  always_comb begin
    mem_addr_s = raddr_r;
    case (state_r)
      ST_WR:   mem_addr_s = waddr_r;
      ST_RD1:  mem_addr_s = raddr_r;
      ST_RD2:  mem_addr_s = raddr_p1_s;
      default: mem_addr_s = raddr_r;
    endcase
  end

  assign mem_idx_s = mem_addr_s[DEPTH_LOG2-1:0];
  assign mem_ok_s  = addr_in_range(mem_addr_s);
  assign ram_q_s   = ram_r[mem_idx_s];

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_REQ) begin
          state_next_s    = ST_AFTER_ACCEPT;
          wait_cnt_next_s = 4'd0;
        end else begin
          state_next_s    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_next_s    = ST_WR;
          wait_cnt_next_s = 4'd0;
        end else begin
          wait_cnt_next_s = wait_cnt_r + 4'd1;
        end
      end
      ST_WR:   state_next_s = ST_RD1;
      ST_RD1:  state_next_s = ST_RD2;
      ST_RD2:  state_next_s = ST_ACK;
      ST_ACK:  state_next_s = ST_IDLE;
      default: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Capture request fields at accept; they stay frozen for the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      raddr_r <= 16'd0;
      waddr_r <= 16'd0;
      wdata_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_IDLE && i_REQ) begin
      we_r    <= i_WE;
      raddr_r <= i_RADDR;
      waddr_r <= i_WADDR;
      wdata_r <= i_WDATA;
    end
  end

  // RAM write port; contents survive reset, but a reset in WR blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ST_WR && we_r && mem_ok_s) begin
      ram_r[mem_idx_s] <= wdata_r;
    end
  end

  // Registered outputs. ACK/BUSY/ERR are derived from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r  <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      op1_r  <= {DATA_W{1'b0}};
      op2_r  <= {DATA_W{1'b0}};
    end else begin
      ack_r  <= (state_next_s == ST_ACK);
      busy_r <= (state_next_s != ST_IDLE);
      err_r  <= (state_next_s == ST_ACK) ? err_s : 1'b0;
      if (state_r == ST_RD1) begin
        op1_r <= mem_ok_s ? ram_q_s : {DATA_W{1'b0}};
      end
      if (state_r == ST_RD2) begin
        op2_r <= mem_ok_s ? ram_q_s : {DATA_W{1'b0}};
      end
    end
  end

  assign o_ACK  = ack_r;
  assign o_BUSY = busy_r;
  assign o_ERR  = err_r;
  assign o_OP1  = op1_r;
  assign o_OP2  = op2_r;

`ifdef MEMRESP_STATS_EN
  logic [15:0] xfer_cnt_r;

  // Saturating count of completed transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_r <= 16'd0;
    end else if (state_r == ST_ACK && xfer_cnt_r != 16'hFFFF) begin
      xfer_cnt_r <= xfer_cnt_r + 16'd1;
    end
  end

  assign o_XFER_CNT = xfer_cnt_r;
`else
  // Statistics disabled: no counter, no o_XFER_CNT port.
`endif

endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed self-checking bench for stack_mem_responder.
// Main DUT uses WAIT_CYCLES=1; a second instance with WAIT_CYCLES=0 checks
// the minimum latency.
module tb_stack_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req0;
  logic        we;
  logic [15:0] raddr;
  logic [15:0] waddr;
  logic [15:0] wdata;

  logic        ack,  busy,  err;
  logic [15:0] op1,  op2;
  logic        ack0, busy0, err0;
  logic [15:0] op1_0, op2_0;
`ifdef MEMRESP_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_mem_responder #(.DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .i_REQ(req), .i_WE(we), .i_RADDR(raddr),
    .i_WADDR(waddr), .i_WDATA(wdata), .o_ACK(ack), .o_OP1(op1), .o_OP2(op2),
    .o_BUSY(busy), .o_ERR(err)
`ifdef MEMRESP_STATS_EN
    , .o_XFER_CNT(xfer_cnt)
`endif
  );

  stack_mem_responder #(.DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_REQ(req0), .i_WE(we), .i_RADDR(raddr),
    .i_WADDR(waddr), .i_WDATA(wdata), .o_ACK(ack0), .o_OP1(op1_0), .o_OP2(op2_0),
    .o_BUSY(busy0), .o_ERR(err0)
`ifdef MEMRESP_STATS_EN
    , .o_XFER_CNT(xfer_cnt0)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one transaction on the main DUT (called #1 after an edge, DUT idle)
  // and return the observed latency and the outputs during the ACK cycle.
  task automatic run_txn(input string tag, input logic t_we, input logic [15:0] t_waddr,
                         input logic [15:0] t_wdata, input logic [15:0] t_raddr,
                         output int lat, output logic [15:0] r_op1,
                         output logic [15:0] r_op2, output logic r_err);
    int  n;
    bit  seen;
    req = 1'b1; we = t_we; waddr = t_waddr; wdata = t_wdata; raddr = t_raddr;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack) seen = 1'b1;
    end
    lat   = seen ? n : -1;
    r_op1 = op1; r_op2 = op2; r_err = err;
    @(posedge clk); #1;
    check_eq({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
  endtask

  int          lat;
  int          n;
  int          acks;
  bit          seen;
  logic [15:0] r1, r2;
  logic        re;

  initial begin
    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0;
    raddr = 16'd0; waddr = 16'd0; wdata = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle behaviour
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ack",  {31'd0, ack},  32'd0);
    check_eq("rst_op1",  {16'd0, op1},  32'd0);
    check_eq("rst_op2",  {16'd0, op2},  32'd0);
    check_eq("rst_err",  {31'd0, err},  32'd0);
`ifdef MEMRESP_STATS_EN
    check_eq("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check_eq("idle_no_ack", acks, 32'd0);

    // Preload RAM[0] and RAM[0x20]
    run_txn("pre0", 1'b1, 16'h0000, 16'h0F0F, 16'h0000, lat, r1, r2, re);
    check_eq("pre0_lat", lat, 32'd4);
    check_eq("pre0_op1", {16'd0, r1}, 32'h0F0F);
    run_txn("pre20", 1'b1, 16'h0020, 16'h1111, 16'h0020, lat, r1, r2, re);
    check_eq("pre20_op1", {16'd0, r1}, 32'h1111);
    check_eq("pre20_err", {31'd0, re}, 32'd0);

    // Write then read
    run_txn("t1", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, lat, r1, r2, re);
    check_eq("t1_lat", lat, 32'd4);
    check_eq("t1_op1", {16'd0, r1}, 32'h0F0F);
    run_txn("t2", 1'b1, 16'h0011, 16'h1234, 16'h0010, lat, r1, r2, re);
    check_eq("t2_lat", lat, 32'd4);
    check_eq("t2_op1", {16'd0, r1}, 32'hBEEF);
    check_eq("t2_op2", {16'd0, r2}, 32'h1234);
    check_eq("t2_err", {31'd0, re}, 32'd0);

    // Boundaries
    run_txn("b3ff", 1'b1, 16'h03FF, 16'h5A5A, 16'h03FF, lat, r1, r2, re);
    check_eq("b3ff_op1", {16'd0, r1}, 32'h5A5A);
    check_eq("b3ff_op2", {16'd0, r2}, 32'h0000);
    check_eq("b3ff_err", {31'd0, re}, 32'd1);
    run_txn("bffff", 1'b0, 16'h0000, 16'h0000, 16'hFFFF, lat, r1, r2, re);
    check_eq("bffff_op1", {16'd0, r1}, 32'h0000);
    check_eq("bffff_op2", {16'd0, r2}, 32'h0F0F);
    check_eq("bffff_err", {31'd0, re}, 32'd1);
    run_txn("w400", 1'b1, 16'h0400, 16'hDEAD, 16'h0010, lat, r1, r2, re);
    check_eq("w400_err", {31'd0, re}, 32'd1);
    check_eq("w400_op1", {16'd0, r1}, 32'hBEEF);
    run_txn("w400rd", 1'b0, 16'h0000, 16'h0000, 16'h0000, lat, r1, r2, re);
    check_eq("w400_ram0", {16'd0, r1}, 32'h0F0F);
    check_eq("w400rd_err", {31'd0, re}, 32'd0);

    // Busy rejection: REQ held, inputs changed right after accept
    req = 1'b1; we = 1'b0; raddr = 16'h0010;
    @(posedge clk); #1;
    raddr = 16'h0000; waddr = 16'h0010; wdata = 16'h0000;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (ack) seen = 1'b1;
    end
    check_eq("busy_lat1", seen ? n : -1, 32'd4);
    check_eq("busy_op1",  {16'd0, op1}, 32'hBEEF);
    check_eq("busy_op2",  {16'd0, op2}, 32'h1234);
    check_eq("busy_err",  {31'd0, err}, 32'd0);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (ack) seen = 1'b1;
    end
    req = 1'b0;
    check_eq("busy_period", seen ? n : -1, 32'd6);
    check_eq("busy_op1b",   {16'd0, op1}, 32'h0F0F);
    @(posedge clk); #1;
`ifdef MEMRESP_STATS_EN
    check_eq("cnt_10", {16'd0, xfer_cnt}, 32'd10);
`endif

    // Reset during WR: accept at edge k, WR cycle is k+1..k+2
    req = 1'b1; we = 1'b1; waddr = 16'h0020; wdata = 16'hAAAA; raddr = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("wrrst_busy", {31'd0, busy}, 32'd0);
    check_eq("wrrst_op1",  {16'd0, op1},  32'd0);
`ifdef MEMRESP_STATS_EN
    check_eq("wrrst_cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check_eq("wrrst_no_ack", acks, 32'd0);
    run_txn("wrrst_rd", 1'b0, 16'h0000, 16'h0000, 16'h0020, lat, r1, r2, re);
    check_eq("wrrst_old", {16'd0, r1}, 32'h1111);
`ifdef MEMRESP_STATS_EN
    check_eq("cnt_after", {16'd0, xfer_cnt}, 32'd1);
`endif

    // Zero wait states: ACK three cycles after accept
    req0 = 1'b1; we = 1'b1; waddr = 16'h0005; wdata = 16'h7777; raddr = 16'h0005;
    @(posedge clk); #1;
    req0 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (ack0) seen = 1'b1;
    end
    check_eq("w0_lat", seen ? n : -1, 32'd3);
    check_eq("w0_op1", {16'd0, op1_0}, 32'h7777);
    check_eq("w0_err", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    check_eq("w0_idle", {31'd0, busy0}, 32'd0);
`ifdef MEMRESP_STATS_EN
    check_eq("w0_cnt", {16'd0, xfer_cnt0}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
